// File: rtl/cache_2way_lru.sv
// 2-way set-associative write-back, write-allocate cache with true LRU per set.
// Sits between a word-addressed 32-bit CPU port and a 128-bit line memory port.
module cache_2way_lru #(
   parameter int unsigned ADDR_W  = 30,
   parameter int unsigned INDEX_W = 3,
   parameter int unsigned TAG_W   = ADDR_W - INDEX_W - 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                cpu_read,
   input  logic                cpu_write,
   input  logic [ADDR_W-1:0]   cpu_addr,
   input  logic [31:0]         cpu_wdata,
   output logic [31:0]         cpu_rdata,
   output logic                cpu_stall,
   output logic                mem_read,
   output logic                mem_write,
   output logic [ADDR_W-3:0]   mem_addr,
   output logic [127:0]        mem_wdata,
   input  logic [127:0]        mem_rdata,
   input  logic                mem_ready
);

   localparam int unsigned SETS   = 2 ** INDEX_W;
   localparam int unsigned WAYS   = 2;
   localparam int unsigned LINE_W = 128;

   typedef enum logic [1:0] {IDLE, WRITE_BACK, READ_FROM_MEM} state_t;

   state_t state, state_nx;

   logic              valid_q [SETS][WAYS];
   logic              dirty_q [SETS][WAYS];
   logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
   logic [LINE_W-1:0] data_q  [SETS][WAYS];
   logic [SETS-1:0]   lru_q;
   logic              victim_q;

   logic [TAG_W-1:0]   tag;
   logic [INDEX_W-1:0] idx;
   logic [1:0]         off;
   logic               req, hit0, hit1, hit, victim_c;

   assign tag  = cpu_addr[ADDR_W-1:INDEX_W+2];
   assign idx  = cpu_addr[INDEX_W+1:2];
   assign off  = cpu_addr[1:0];
   assign req  = cpu_read | cpu_write;
   assign hit0 = valid_q[idx][0] && (tag_q[idx][0] == tag);
   assign hit1 = valid_q[idx][1] && (tag_q[idx][1] == tag);
   assign hit  = hit0 | hit1;

   // Invalid ways are filled first (way0 preferred) before LRU eviction kicks in.
   assign victim_c = !valid_q[idx][0] ? 1'b0 :
                     !valid_q[idx][1] ? 1'b1 : lru_q[idx];

   assign cpu_rdata = data_q[idx][hit1][{off, 5'd0} +: 32];
   assign mem_wdata = data_q[idx][victim_q];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      cpu_stall = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      mem_addr  = '0;
      case (state)
         IDLE: begin
            if (req && !hit) begin
               cpu_stall = 1'b1;
               state_nx  = (valid_q[idx][victim_c] && dirty_q[idx][victim_c]) ?
                           WRITE_BACK : READ_FROM_MEM;
            end
         end
         WRITE_BACK: begin
            cpu_stall = 1'b1;
            mem_write = 1'b1;
            mem_addr  = {tag_q[idx][victim_q], idx};
            if (mem_ready) state_nx = READ_FROM_MEM;
         end
         READ_FROM_MEM: begin
            cpu_stall = 1'b1;
            mem_read  = 1'b1;
            mem_addr  = {tag, idx};
            if (mem_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Line storage, LRU and victim bookkeeping; refill leaves LRU for the following hit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lru_q    <= '0;
         victim_q <= 1'b0;
         for (int unsigned s = 0; s < SETS; s++) begin
            for (int unsigned w = 0; w < WAYS; w++) begin
               valid_q[INDEX_W'(s)][1'(w)] <= 1'b0;
               dirty_q[INDEX_W'(s)][1'(w)] <= 1'b0;
               tag_q[INDEX_W'(s)][1'(w)]   <= '0;
               data_q[INDEX_W'(s)][1'(w)]  <= '0;
            end
         end
      end else begin
         case (state)
            IDLE: begin
               if (req && hit) begin
                  lru_q[idx] <= ~hit1;
                  if (cpu_write) begin
                     data_q[idx][hit1][{off, 5'd0} +: 32] <= cpu_wdata;
                     dirty_q[idx][hit1]                   <= 1'b1;
                  end
               end else if (req) begin
                  victim_q <= victim_c;
               end
            end
            READ_FROM_MEM: begin
               if (mem_ready) begin
                  valid_q[idx][victim_q] <= 1'b1;
                  dirty_q[idx][victim_q] <= 1'b0;
                  tag_q[idx][victim_q]   <= tag;
                  data_q[idx][victim_q]  <= mem_rdata;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cache_2way_lru.sv
// Bench for cache_2way_lru: directed vector table, reset-abort sequence and a
// randomized phase checked against a recency-ordered set model.
module tb_cache_2way_lru;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         cpu_read = 1'b0, cpu_write = 1'b0;
   logic [29:0]  cpu_addr = '0;
   logic [31:0]  cpu_wdata = '0;
   logic [31:0]  cpu_rdata;
   logic         cpu_stall, mem_read, mem_write;
   logic [27:0]  mem_addr;
   logic [127:0] mem_wdata;
   logic [127:0] mem_rdata = '0;
   logic         mem_ready = 1'b0;

   cache_2way_lru dut (
      .clk(clk), .rst_n(rst_n), .cpu_read(cpu_read), .cpu_write(cpu_write),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
      .cpu_stall(cpu_stall), .mem_read(mem_read), .mem_write(mem_write),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_ready(mem_ready)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit both_high = 1'b0;

   logic [127:0] dmem [bit [27:0]];
   logic [127:0] mmem [bit [27:0]];

   logic [24:0]  mtag   [8][2];
   bit           mdirty [8][2];
   logic [127:0] mdata  [8][2];
   int           mcnt   [8];

   typedef struct {
      bit           rd;
      bit           wr;
      logic [29:0]  addr;
      logic [31:0]  wd;
      int           lat;
      int           stall;
      bit           chk_rd;
      logic [31:0]  rdata;
      bit           wb;
      logic [27:0]  wb_addr;
      logic [127:0] wb_data;
   } vec_t;

   vec_t tbl [14];

   function automatic logic [127:0] line_init(bit [27:0] l);
      return {l, 4'd3, l, 4'd2, l, 4'd1, l, 4'd0};
   endfunction

   function automatic logic [127:0] dget(bit [27:0] l);
      return dmem.exists(l) ? dmem[l] : line_init(l);
   endfunction

   function automatic logic [127:0] mget(bit [27:0] l);
      return mmem.exists(l) ? mmem[l] : line_init(l);
   endfunction

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      for (int s = 0; s < 8; s++) mcnt[s] = 0;
   endtask

   // Each set is an MRU-first list of at most two lines; a miss evicts the tail.
   task automatic model_access(input bit wr, input logic [29:0] addr, input logic [31:0] wd,
                               input int lat, output int st, output logic [31:0] rd,
                               output bit wb, output logic [27:0] wba, output logic [127:0] wbd);
      int          idx = int'(addr[4:2]);
      logic [24:0] tg  = addr[29:5];
      int          off = int'(addr[1:0]);
      int          hit = -1;
      logic [24:0]  t_t;
      bit           t_d;
      logic [127:0] t_l;
      wb = 1'b0; wba = '0; wbd = '0; st = 0;
      for (int i = 0; i < mcnt[idx]; i++) if (mtag[idx][i] == tg) hit = i;
      if (hit < 0) begin
         st = lat + 2;
         if (mcnt[idx] == 2) begin
            if (mdirty[idx][1]) begin
               wb  = 1'b1;
               wba = {mtag[idx][1], 3'(idx)};
               wbd = mdata[idx][1];
               mmem[wba] = wbd;
               st += lat + 1;
            end
         end else begin
            mcnt[idx]++;
         end
         mtag[idx][1] = mtag[idx][0]; mdirty[idx][1] = mdirty[idx][0]; mdata[idx][1] = mdata[idx][0];
         mtag[idx][0] = tg; mdirty[idx][0] = 1'b0; mdata[idx][0] = mget({tg, 3'(idx)});
      end else if (hit == 1) begin
         t_t = mtag[idx][0]; t_d = mdirty[idx][0]; t_l = mdata[idx][0];
         mtag[idx][0] = mtag[idx][1]; mdirty[idx][0] = mdirty[idx][1]; mdata[idx][0] = mdata[idx][1];
         mtag[idx][1] = t_t; mdirty[idx][1] = t_d; mdata[idx][1] = t_l;
      end
      rd = mdata[idx][0][off*32 +: 32];
      if (wr) begin
         mdata[idx][0][off*32 +: 32] = wd;
         mdirty[idx][0] = 1'b1;
      end
   endtask

   // Drives one CPU access and plays memory until the stall clears.
   task automatic run_access(input bit rd, input bit wr, input logic [29:0] addr,
                             input logic [31:0] wd, input int lat,
                             output int st, output logic [31:0] rdata, output bit wb,
                             output logic [27:0] wba, output logic [127:0] wbd,
                             output bit fill, output logic [27:0] fa, output bit tmo);
      int cnt = 0;
      @(negedge clk);
      cpu_read = rd; cpu_write = wr; cpu_addr = addr; cpu_wdata = wd; mem_ready = 1'b0;
      st = 0; rdata = '0; wb = 1'b0; wba = '0; wbd = '0; fill = 1'b0; fa = '0; tmo = 1'b1;
      for (int c = 0; c < 64; c++) begin
         #1;
         if (mem_read && mem_write) both_high = 1'b1;
         if (!cpu_stall) begin
            rdata = cpu_rdata;
            tmo = 1'b0;
            break;
         end
         st++;
         if (mem_read || mem_write) begin
            if (mem_write) begin
               wb = 1'b1; wba = mem_addr; wbd = mem_wdata;
            end else begin
               fill = 1'b1; fa = mem_addr; mem_rdata = dget(mem_addr);
            end
            if (cnt == lat) begin
               mem_ready = 1'b1;
               cnt = 0;
               if (mem_write) dmem[mem_addr] = mem_wdata;
            end else begin
               cnt++;
            end
         end
         @(negedge clk);
         mem_ready = 1'b0;
      end
   endtask

   task automatic access_checked(input bit rd, input bit wr, input logic [29:0] addr,
                                 input logic [31:0] wd, input int lat,
                                 output int st, output logic [31:0] rdata,
                                 output bit wb, output logic [27:0] wba, output logic [127:0] wbd);
      int           e_st;
      logic [31:0]  e_rd;
      bit           e_wb, fill, tmo;
      logic [27:0]  e_wba, fa;
      logic [127:0] e_wbd;
      model_access(wr, addr, wd, lat, e_st, e_rd, e_wb, e_wba, e_wbd);
      run_access(rd, wr, addr, wd, lat, st, rdata, wb, wba, wbd, fill, fa, tmo);
      chk("timeout", 128'(tmo), 128'(0));
      chk("stall_cycles", 128'(st), 128'(e_st));
      chk("write_back", 128'(wb), 128'(e_wb));
      if (e_wb) begin
         chk("wb_addr", 128'(wba), 128'(e_wba));
         chk("wb_data", wbd, e_wbd);
      end
      chk("fill", 128'(fill), 128'(e_st != 0));
      if (e_st != 0) chk("fill_addr", 128'(fa), 128'(addr[29:2]));
      if (rd && !wr) chk("rdata", 128'(rdata), 128'(e_rd));
   endtask

   initial begin
      int           st;
      logic [31:0]  rdata;
      bit           wb;
      logic [27:0]  wba;
      logic [127:0] wbd;
      bit           seen;

      tbl[0]  = '{1, 0, 30'h24, 32'h0,        2, 4, 1, 32'h2222_1111, 0, 28'h0, 128'h0};
      tbl[1]  = '{0, 1, 30'h26, 32'hDEADBEEF, 0, 0, 0, 32'h0,         0, 28'h0, 128'h0};
      tbl[2]  = '{1, 0, 30'h26, 32'h0,        0, 0, 1, 32'hDEADBEEF,  0, 28'h0, 128'h0};
      tbl[3]  = '{1, 0, 30'h44, 32'h0,        1, 3, 0, 32'h0,         0, 28'h0, 128'h0};
      tbl[4]  = '{1, 0, 30'h24, 32'h0,        0, 0, 1, 32'h2222_1111, 0, 28'h0, 128'h0};
      tbl[5]  = '{1, 0, 30'h44, 32'h0,        0, 0, 0, 32'h0,         0, 28'h0, 128'h0};
      tbl[6]  = '{1, 0, 30'h44, 32'h0,        0, 0, 0, 32'h0,         0, 28'h0, 128'h0};
      tbl[7]  = '{1, 0, 30'h24, 32'h0,        0, 0, 1, 32'h2222_1111, 0, 28'h0, 128'h0};
      tbl[8]  = '{1, 0, 30'h64, 32'h0,        0, 2, 0, 32'h0,         0, 28'h0, 128'h0};
      tbl[9]  = '{1, 0, 30'h26, 32'h0,        0, 0, 1, 32'hDEADBEEF,  0, 28'h0, 128'h0};
      tbl[10] = '{1, 0, 30'h64, 32'h0,        0, 0, 0, 32'h0,         0, 28'h0, 128'h0};
      tbl[11] = '{1, 0, 30'h84, 32'h0,        1, 5, 0, 32'h0,         1, 28'h9,
                  128'h0000_0000_DEAD_BEEF_4444_3333_2222_1111};
      tbl[12] = '{1, 1, 30'h85, 32'h1234_5678, 0, 0, 0, 32'h0,        0, 28'h0, 128'h0};
      tbl[13] = '{1, 0, 30'h85, 32'h0,        0, 0, 1, 32'h1234_5678, 0, 28'h0, 128'h0};

      dmem[28'h9] = 128'h4444_3333_2222_1111;
      mmem[28'h9] = 128'h4444_3333_2222_1111;
      model_clear();

      repeat (2) @(negedge clk);
      #1;
      chk("reset_stall", 128'(cpu_stall), 128'(0));
      chk("reset_mem_read", 128'(mem_read), 128'(0));
      chk("reset_mem_write", 128'(mem_write), 128'(0));
      chk("reset_mem_addr", 128'(mem_addr), 128'(0));
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 14; i++) begin
         access_checked(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wd, tbl[i].lat,
                        st, rdata, wb, wba, wbd);
         chk($sformatf("tbl%0d_stall", i), 128'(st), 128'(tbl[i].stall));
         chk($sformatf("tbl%0d_wb", i), 128'(wb), 128'(tbl[i].wb));
         if (tbl[i].wb) begin
            chk($sformatf("tbl%0d_wb_addr", i), 128'(wba), 128'(tbl[i].wb_addr));
            chk($sformatf("tbl%0d_wb_data", i), wbd, tbl[i].wb_data);
         end
         if (tbl[i].chk_rd) chk($sformatf("tbl%0d_rdata", i), 128'(rdata), 128'(tbl[i].rdata));
      end

      // Make the dirty tag-4 line LRU, then abort its write-back with reset.
      access_checked(1, 0, 30'h64, 32'h0, 0, st, rdata, wb, wba, wbd);
      @(negedge clk);
      cpu_read = 1'b1; cpu_write = 1'b0; cpu_addr = 30'hA4; mem_ready = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 20; c++) begin
         #1;
         if (mem_write) begin
            seen = 1'b1;
            break;
         end
         @(negedge clk);
      end
      chk("abort_saw_mem_write", 128'(seen), 128'(1));
      #1;
      rst_n = 1'b0; cpu_read = 1'b0;
      #1;
      chk("abort_mem_write_async", 128'(mem_write), 128'(0));
      chk("abort_mem_read", 128'(mem_read), 128'(0));
      chk("abort_stall", 128'(cpu_stall), 128'(0));
      @(negedge clk);
      rst_n = 1'b1;
      model_clear();
      access_checked(1, 0, 30'h85, 32'h0, 1, st, rdata, wb, wba, wbd);
      chk("abort_reread_misses", 128'(st != 0), 128'(1));
      chk("abort_dirty_lost", 128'(rdata), 128'(32'h0000_0211));

      for (int n = 0; n < 300; n++) begin
         int          kind = int'($urandom_range(0, 2));
         int          lat  = int'($urandom_range(0, 3));
         int          tg   = int'($urandom_range(0, 5));
         int          ix   = ($urandom_range(0, 1) == 0) ? 1 : 6;
         int          of   = int'($urandom_range(0, 3));
         logic [29:0] a    = {25'(tg), 3'(ix), 2'(of)};
         access_checked(kind != 1, kind != 0, a, $urandom, lat, st, rdata, wb, wba, wbd);
      end

      @(negedge clk);
      cpu_read = 1'b0; cpu_write = 1'b0;
      chk("mem_rw_exclusive", 128'(both_high), 128'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cache_2way_lru.md
Name: cache_2way_lru

Overview:
- Parametrised successor of the team's direct-mapped write-back cache: 2-way set-associative, write-back, write-allocate, with true LRU replacement per set.
- Sits between the MIPS core (word-addressed, 32-bit) and main memory (128-bit line interface with a ready handshake).
- Used for both I-cache and D-cache instances.
- Number of sets and address width are parameters; line size stays fixed at 4 words.

Parameters:
- ADDR_W, 30, CPU word-address width.
- INDEX_W, 3, set-index width; sets = 2**INDEX_W.
- TAG_W, ADDR_W-INDEX_W-2, derived tag width; not to be overridden.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- cpu_read  in  1  CPU read request, held until cpu_stall is low.
- cpu_write  in  1  CPU write request, held until cpu_stall is low.
- cpu_addr  in  ADDR_W  word address: tag=[ADDR_W-1:INDEX_W+2], index=[INDEX_W+1:2], offset=[1:0].
- cpu_wdata  in  32  write data.
- cpu_rdata  out  32  read data, combinational, valid when request and !cpu_stall.
- cpu_stall  out  1  CPU must hold request and pipeline.
- mem_read  out  1  line-fill request.
- mem_write  out  1  line write-back request.
- mem_addr  out  ADDR_W-2  line address {tag,index}.
- mem_wdata  out  128  victim line data; word k at bits [32k+31:32k].
- mem_rdata  in  128  fill data, same word packing.
- mem_ready  in  1  one-cycle completion pulse for the current mem_read/mem_write.

Behaviour:
- Storage per set: two ways, each holding valid, dirty, tag[TAG_W] and data[128]; one lru bit per set naming the least-recently-used way.
- Reset (async): state=IDLE; all valid, dirty and lru bits=0; victim register=0; mem_read=mem_write=0; mem_addr=0; cpu_stall=0. Data/tag arrays are also cleared.
- Request: req = cpu_read|cpu_write. When both are high, the access is treated as a write.
- Hit: hit_w = valid_w & (tag_w==cpu_tag), per way. Both ways hitting cannot occur by construction.
- FSM states: IDLE, WRITE_BACK, READ_FROM_MEM.
- IDLE, req & hit:
  - Zero-latency: cpu_stall=0; cpu_rdata=hit way word[offset] in the same cycle.
  - Write: the word is updated at the clock edge and dirty is set.
  - lru <= other way, on reads and writes alike.
  - State stays IDLE.
- IDLE, req & miss:
  - cpu_stall=1 combinationally in the same cycle.
  - Victim = the first invalid way (way0 preferred), else way[lru]; the victim is registered.
  - Next state is WRITE_BACK if the victim is valid & dirty, else READ_FROM_MEM.
- IDLE, no req: stays IDLE; stall=0; mem_read=mem_write=0; mem_addr=0.
- WRITE_BACK:
  - Outputs: mem_write=1; mem_addr={victim tag,index}; mem_wdata=victim data; cpu_stall=1.
  - Holds until mem_ready, then goes to READ_FROM_MEM.
  - The victim's dirty bit is not cleared here; refill overwrites the line.
- READ_FROM_MEM:
  - Outputs: mem_read=1; mem_addr={cpu_tag,index}; cpu_stall=1.
  - On mem_ready: the victim way takes valid=1, dirty=0, tag=cpu_tag, data=mem_rdata; state goes to IDLE.
  - lru is left unchanged on refill; the IDLE hit on the following cycle updates it.
- Post-refill:
  - Next cycle, IDLE sees a hit: the read returns data, or the write merges and sets dirty.
  - Miss-to-data latency is 1 cycle after the final mem_ready.
- mem_read and mem_write are never high together; both are driven from the registered state only.
- cpu_addr and request must be stable while cpu_stall=1. The block does not re-check them mid-miss.
- mem_ready while in IDLE is ignored.
- mem_ready arriving in the same cycle the state is entered is legal and accepted.
- Reset mid-miss: the transaction is abandoned immediately. mem_read/mem_write drop asynchronously and all lines are invalidated. Memory must tolerate the aborted request.
- No flush port. Dirty data is lost on reset by design.

Test Plan:
- Cold read miss:
  - Stimulus: after reset, read addr 0x0000_0024 (index 1, offset 0); memory returns 128'h4444_3333_2222_1111 after 3 cycles.
  - Required: mem_read with mem_addr=0x000_0009; stall until the cycle after mem_ready; cpu_rdata=0x2222_1111 then; no mem_write at any point.
- Write hit:
  - Stimulus: on the same line, write 0xDEADBEEF to offset 2, then read offset 2.
  - Required: no stall on either access; read returns 0xDEADBEEF; way0 dirty=1.
- Two-way fill without eviction:
  - Stimulus: read tags A then B at index 1, then re-read A and B.
  - Required: two fills with no write-back; the re-reads of A and B both hit with zero stall.
- LRU eviction with write-back:
  - Stimulus: A dirty, B clean; touch B, then A; then read tag C at the same index.
  - Required: B (LRU, clean) is replaced, with no mem_write.
  - Stimulus: repeat with A as LRU.
  - Required: mem_write of A's line with the 0xDEADBEEF word at bits [95:64], then the fill of C.
- Read+write together and mem_ready latency:
  - Stimulus: cpu_read=cpu_write=1.
  - Required: behaves as a write.
  - Stimulus: mem_ready high on the first cycle of READ_FROM_MEM.
  - Required: one-cycle fill, stall for exactly 2 cycles total.
- Reset mid-WRITE_BACK:
  - Stimulus: assert rst_n=0 during mem_write=1.
  - Required: mem_write falls without waiting for clk; cpu_stall=0; a subsequent read of the previously dirty address misses.
